demux1x3_router: RTL
====================

Name: demux1x3_router

Overview:
- Counterpart to the team's 3:1 multiplexer. Takes one input stream and steers each word to one of three output channels, selected by a 2-bit select that travels with the word.
- Each output channel has a one-entry registered buffer and a valid/ready handshake, so a stalled consumer blocks only its own channel.
- Sits downstream of a single producer and fans out to three independent consumers.

Parameters:
- WIDTH, 8, data word width in bits.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  router accepts the word this cycle.
- in_data  input  WIDTH  input word.
- in_sel  input  2  destination: 00 = ch0, 01 = ch1, 10 = ch2, 11 = illegal.
- o0_valid / o1_valid / o2_valid  output  1  channel buffer holds a word.
- o0_ready / o1_ready / o2_ready  input  1  consumer takes the word.
- o0_data / o1_data / o2_data  output  WIDTH  channel buffer contents.
- err_pulse  output  1  one-cycle pulse when an illegal-select word is accepted.
- err_cnt  output  CNT_W  count of illegal-select words, saturating.

Behaviour:
- Reset (asynchronous, active-high, effective immediately):
  - oN_valid = 0, oN_data = 0, err_pulse = 0, err_cnt = 0.
  - Words buffered at reset are discarded; no partial state survives.
- Transfers: an input transfer happens on a clk edge where in_valid && in_ready. An output transfer on channel N happens where oN_valid && oN_ready.
- Per-channel buffer state: EMPTY (oN_valid = 0) or FULL (oN_valid = 1). Transitions:
  - EMPTY -> FULL on an input transfer to N.
  - FULL -> EMPTY on an output transfer with no input transfer to N.
  - FULL -> FULL on an output transfer and an input transfer to N in the same cycle. The new word is loaded and valid stays 1 (no bubble).
  - FULL holds while oN_ready = 0; oN_data stays stable.
- in_ready (combinational from in_sel and the channel state; no dependency on in_valid):
  - sel 00/01/10: in_ready = !oN_valid || oN_ready for the selected channel N.
  - sel 11 (macro off): in_ready = 1.
- Latency: an accepted word appears on oN_valid/oN_data on the next clk edge (1 cycle). Full throughput is 1 word/cycle while the targeted consumer is always ready.
- Routing is in order per channel only. Consecutive words to different channels may complete in any order relative to each other.
- Illegal select (sel 11, macro off):
  - The word is accepted and dropped; no channel changes.
  - err_pulse = 1 for the following cycle only.
  - err_cnt increments by 1 and saturates at all-ones (255 by default), with no wrap.
- Non-selected channels are unaffected by an input transfer and may drain in the same cycle.
- oN_data changes only on a load; it is not cleared on drain.
- err_pulse is registered and is 0 in every cycle not following an illegal accept.

Optional Feature:
- Macro: DEMUX_BROADCAST_EN.
- Defined: sel 11 is a broadcast.
  - in_ready = AND over all three channels of (!oN_valid || oN_ready).
  - On transfer, the word is loaded into all three buffers in the same cycle.
  - err_pulse is tied to 0 and err_cnt held at 0. Both ports remain present.
- Not defined: sel 11 is illegal and handled as in Behaviour.

Test Plan:
- Reset mid-operation: fill ch1 with 0x5A, assert rst asynchronously between edges -> o1_valid drops to 0 immediately, all data = 0, err_cnt = 0. After release, ch1 accepts a new word on the first edge.
- Routing: oN_ready = 1 throughout; send 0x11/sel 00, 0x22/sel 01, 0x33/sel 10 back-to-back -> each appears on o0/o1/o2 respectively one cycle after acceptance. in_ready stays 1 and no channel shows a spurious valid.
- Backpressure and isolation:
  - Hold o0_ready = 0 and send 0xA1 then 0xA2, both sel 00 -> o0 holds 0xA1 and in_ready = 0 for the second word.
  - Meanwhile 0xB1/sel 01 is accepted.
  - Raise o0_ready -> 0xA1 drains and 0xA2 loads in the same edge with o0_valid staying 1.
- Illegal select, macro off: send 0xFF/sel 11 -> in_ready = 1, no oN_valid changes, err_pulse high exactly one cycle, err_cnt = 1. Send 300 such words -> err_cnt = 255, no wrap.
- Broadcast, macro on:
  - Hold o2 FULL with o2_ready = 0 and send 0x77/sel 11 -> in_ready = 0.
  - Release o2_ready -> 0x77 loads into all three channels on the same edge; err_cnt remains 0.

Source files
------------

// File: rtl/demux1x3_router.sv
// 1:3 stream demultiplexer with one registered buffer per output channel.
// Define DEMUX_BROADCAST_EN to turn select 11 into a broadcast to all channels.
module demux1x3_router #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_sel,
   output logic             o0_valid,
   input  logic             o0_ready,
   output logic [WIDTH-1:0] o0_data,
   output logic             o1_valid,
   input  logic             o1_ready,
   output logic [WIDTH-1:0] o1_data,
   output logic             o2_valid,
   input  logic             o2_ready,
   output logic [WIDTH-1:0] o2_data,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_cnt
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } buf_state_t;

   buf_state_t       r_state     [3];
   buf_state_t       w_state_nxt [3];
   logic [WIDTH-1:0] r_data      [3];

   logic [2:0] w_o_ready;
   logic [2:0] w_free;
   logic [2:0] w_load;
   logic       w_in_xfer;
   logic       w_bcast;

   assign w_o_ready = {o2_ready, o1_ready, o0_ready};

`ifdef DEMUX_BROADCAST_EN
   assign w_bcast = (in_sel == 2'b11);
`else
   assign w_bcast = 1'b0;
`endif

   // A channel can take a word if empty or if it drains on this same edge.
   always_comb begin
      w_free = '0;
      for (int unsigned i = 0; i < 3; i++) begin
         w_free[i] = (r_state[i] == ST_EMPTY) || w_o_ready[i];
      end
   end

   always_comb begin
      in_ready = 1'b1;
      case (in_sel)
         2'b00:   in_ready = w_free[0];
         2'b01:   in_ready = w_free[1];
         2'b10:   in_ready = w_free[2];
`ifdef DEMUX_BROADCAST_EN
         default: in_ready = &w_free;
`else
         default: in_ready = 1'b1;
`endif
      endcase
   end

   assign w_in_xfer = in_valid && in_ready;

   always_comb begin
      w_load = '0;
      for (int unsigned i = 0; i < 3; i++) begin
         w_load[i] = w_in_xfer && ((in_sel == 2'(i)) || w_bcast);
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < 3; i++) begin
         w_state_nxt[i] = r_state[i];
         case (r_state[i])
            ST_EMPTY: if (w_load[i]) w_state_nxt[i] = ST_FULL;
            ST_FULL: begin
               if (w_load[i])          w_state_nxt[i] = ST_FULL;
               else if (w_o_ready[i])  w_state_nxt[i] = ST_EMPTY;
            end
            default: w_state_nxt[i] = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < 3; i++) begin
            r_state[i] <= ST_EMPTY;
            r_data[i]  <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 3; i++) begin
            r_state[i] <= w_state_nxt[i];
            if (w_load[i]) r_data[i] <= in_data;
         end
      end
   end

   assign o0_valid = (r_state[0] == ST_FULL);
   assign o1_valid = (r_state[1] == ST_FULL);
   assign o2_valid = (r_state[2] == ST_FULL);
   assign o0_data  = r_data[0];
   assign o1_data  = r_data[1];
   assign o2_data  = r_data[2];

`ifdef DEMUX_BROADCAST_EN
   assign err_pulse = 1'b0;
   assign err_cnt   = '0;
`else
   logic             r_err_pulse;
   logic [CNT_W-1:0] r_err_cnt;
   logic             w_illegal;

   assign w_illegal = w_in_xfer && (in_sel == 2'b11);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_pulse <= 1'b0;
         r_err_cnt   <= '0;
      end else begin
         r_err_pulse <= w_illegal;
         if (w_illegal && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign err_pulse = r_err_pulse;
   assign err_cnt   = r_err_cnt;
`endif

endmodule
